// File: rtl/riscv_pkg.sv
// Shared RV32M multiply/divide definitions: Funct3 operation codes, the Funct7
// selector and the iterative unit's state encoding, plus small decode helpers.
package riscv_pkg;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic op_signed_a(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_signed_b(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One radix-2 iteration on the shared 2*DATA_W accumulator: shift-add for
// multiply ({hi, multiplier}) or restoring shift-subtract for divide ({rem, quot}).
module muldiv_iter_core #(
  parameter int DATA_W = 32
) (
  input  logic                  is_div,
  input  logic [2*DATA_W-1:0]   acc_i,
  input  logic [DATA_W-1:0]     opnd_i,
  output logic [2*DATA_W-1:0]   acc_o
);

  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   diff;

  always_comb begin
    mul_sum = {1'b0, acc_i[2*DATA_W-1:DATA_W]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh  = acc_i[2*DATA_W-1:DATA_W-1];
    // The remainder is always below the divisor, so bit DATA_W of the
    // difference is set exactly when the trial subtraction borrows.
    diff    = rem_sh - {1'b0, opnd_i};

    if (!is_div) begin
      acc_o = {mul_sum, acc_i[DATA_W-1:1]};
    end else if (!diff[DATA_W]) begin
      acc_o = {diff[DATA_W-1:0], acc_i[DATA_W-2:0], 1'b1};
    end else begin
      acc_o = {rem_sh[DATA_W-1:0], acc_i[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: captures operands on Start, works on
// magnitudes for DATA_W iterations, applies the sign and pulses Done.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic              Flush,
  input  logic [2:0]        Funct3,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Result
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  muldiv_state_e       state_q, state_d;
  muldiv_op_e          op_q, op_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic                neg_q, neg_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                done_q, done_d;

  logic                a_neg, b_neg, is_div;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [2*DATA_W-1:0] iter_acc, mul_full;
  logic [DATA_W-1:0]   div_src, div_fix, fix_result;

  assign is_div = op_is_div(op_q);
  assign a_neg  = op_signed_a(op_q) && a_q[DATA_W-1];
  assign b_neg  = op_signed_b(op_q) && b_q[DATA_W-1];
  assign a_mag  = a_neg ? -a_q : a_q;
  assign b_mag  = b_neg ? -b_q : b_q;

  muldiv_iter_core #(.DATA_W(DATA_W)) u_iter (
    .is_div (is_div),
    .acc_i  (prod_q),
    .opnd_i (opnd_q),
    .acc_o  (iter_acc)
  );

  // REM/REMU read the remainder half, DIV/DIVU the quotient half.
  assign mul_full   = neg_q ? -prod_q : prod_q;
  assign div_src    = op_q[1] ? prod_q[2*DATA_W-1:DATA_W] : prod_q[DATA_W-1:0];
  assign div_fix    = neg_q ? -div_src : div_src;
  assign fix_result = is_div ? div_fix
                    : (op_q == OP_MUL) ? mul_full[DATA_W-1:0] : mul_full[2*DATA_W-1:DATA_W];

  always_comb begin
    // NOTE: every _d takes its held value first, so no branch below can infer a latch.
    state_d  = state_q;
    op_d     = op_q;
    count_d  = count_q;
    a_d      = a_q;
    b_d      = b_q;
    opnd_d   = opnd_q;
    prod_d   = prod_q;
    neg_d    = neg_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (Start && !Flush) begin
          op_d    = muldiv_op_e'(Funct3);
          a_d     = SrcA;
          b_d     = SrcB;
          state_d = PREP;
        end
      end
      PREP: begin
        count_d = CNT_W'(DATA_W - 1);
        if (!is_div) begin
          opnd_d = a_mag;
          prod_d = {{DATA_W{1'b0}}, b_mag};
          neg_d  = a_neg ^ b_neg;
        end else begin
          opnd_d = b_mag;
          prod_d = {{DATA_W{1'b0}}, a_mag};
          neg_d  = op_q[1] ? a_neg : (a_neg ^ b_neg);
        end
        if (is_div && (b_q == '0)) begin
          result_d = op_q[1] ? a_q : '1;
          state_d  = DONE;
        end else if (op_signed_b(op_q) && is_div && (a_q == MIN_NEG) && (b_q == '1)) begin
          result_d = op_q[1] ? '0 : MIN_NEG;
          state_d  = DONE;
        end else begin
          state_d = CALC;
        end
      end
      CALC: begin
        prod_d  = iter_acc;
        count_d = count_q - CNT_W'(1);
        if (count_q == '0) state_d = FIX;
      end
      FIX: begin
        result_d = fix_result;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (Flush && (state_q != IDLE)) begin
      state_d  = IDLE;
      result_d = result_q;
    end

    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      count_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      opnd_q   <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking only; all next-state values were settled in the always_comb.
      state_q  <= state_d;
      op_q     <= op_d;
      count_q  <= count_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opnd_q   <= opnd_d;
      prod_q   <= prod_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign Busy   = (state_q == PREP) || (state_q == CALC) || (state_q == FIX);
  assign Done   = done_q;
  assign Result = result_q;

endmodule
